mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multicycle MIPS main control FSM; sits directly upstream of the ALU and drives its 4-bit ALUOp.
//  Sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction and waits on memory through a ready handshake.
//  Generates all datapath strobes. Consumes ALU 'zero' for BEQ.
// PARAMETERS
//  WAIT_W  4  width of memory-wait timeout counter; timeout = 2**WAIT_W-1 cycles
// PORTS
//  clk         in   1  single clock, rising edge
//  rst_n       in   1  synchronous reset, active-low
//  opcode      in   6  IR[31:26]
//  funct       in   6  IR[5:0]
//  zero        in   1  ALU zero flag
//  mem_ready   in   1  memory done for current MemRead/MemWrite
//  ALUOp       out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SUB+zero
//  ALUSrcA     out  1  0 = PC, 1 = regA
//  ALUSrcB     out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  PCSource    out  2  00 ALU result, 01 ALUOut, 10 jump target
//  pc_en       out  1  PCWrite | (PCWriteCond & zero)
//  IorD, MemRead, MemWrite, IRWrite, RegDst, RegWrite, MemtoReg  out  1 each  datapath strobes
//  mem_err     out  1  sticky: memory wait timed out
//  illegal_op  out  1  sticky: illegal opcode/funct (0 unless ILLEGAL_TRAP_EN)
// BEHAVIOUR
//  - rst_n=0 at posedge: state<=IDLE, counter<=0, mem_err<=0, illegal_op<=0, funct_q<=0.
//    IDLE drives every output 0. Reset mid-instruction abandons it; no strobe may fire on the reset cycle.
//  - IDLE -> FETCH unconditionally. Outputs are decoded from state. IRWrite and PCWrite are also gated by mem_ready.
//  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=0010, PCSource=00.
//    When mem_ready=1: IRWrite=1, pc_en=1, go to DECODE. Otherwise stay in FETCH.
//  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=0010; latch funct_q<=funct. Next state by opcode:
//    000000 -> EXEC; 100011/101011 -> MEMADR; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDI_EX; other -> illegal.
//  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=0010 -> MEMRD for lw, MEMWR for sw.
//  - MEMRD: MemRead=1, IorD=1; go to MEMWB on mem_ready.
//  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
//  - MEMWR: MemWrite=1, IorD=1; go to FETCH on mem_ready.
//  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp mapped from funct_q:
//    100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, other -> illegal.
//    Legal funct -> RTYPE_WB.
//  - RTYPE_WB: RegDst=1, RegWrite=1, MemtoReg=0; ALUOp held -> FETCH.
//  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=0111, PCWriteCond=1, PCSource=01 -> FETCH.
//    pc_en = zero, evaluated in the same cycle.
//  - JUMP: PCWrite=1, PCSource=10 -> FETCH.
//  - ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=0010 -> ADDI_WB.
//  - ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
//  - Wait counter runs in FETCH/MEMRD/MEMWR. It clears on entry and on mem_ready.
//    On reaching 2**WAIT_W-1 with mem_ready=0: mem_err<=1, go to FETCH with no IRWrite/PC/reg strobe.
//    If mem_ready=1 in the expiry cycle, ready wins.
//  - Strobes not listed for a state are 0. ALUOp is 0000 in IDLE and JUMP.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//    illegal opcode/funct -> TRAP; illegal_op<=1; all strobes 0; TRAP is held until rst_n=0.
//  ILLEGAL_TRAP_EN undefined:
//    illegal opcode/funct -> FETCH (executes as NOP); illegal_op tied 0; no TRAP state.
// TESTING
//  - Hold rst_n=0 2 cycles then release.
//    -> all outputs 0 in IDLE; FETCH with MemRead=1, ALUOp=0010 on the next cycle.
//  - add (op 000000, funct 100000), mem_ready=1 in FETCH.
//    -> FETCH, DECODE, EXEC (ALUOp=0010), RTYPE_WB (RegWrite=1, RegDst=1); 4 cycles total.
//  - lw (100011), mem_ready held low 3 cycles in MEMRD.
//    -> MemRead/IorD=1 held for 4 cycles, then MEMWB with MemtoReg=1.
//  - beq (000100) run twice.
//    -> zero=1: pc_en=1, PCSource=01, ALUOp=0111. zero=0: pc_en=0.
//  - WAIT_W=4, mem_ready=0 for 20 cycles in FETCH.
//    -> mem_err=1 after 15 cycles; FETCH re-entered; IRWrite never asserted.
//  - opcode 111111.
//    -> with ILLEGAL_TRAP_EN: illegal_op=1, stuck in TRAP until reset.
//    -> without it: back to FETCH with no strobes.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle MIPS main controller and its datapath.
// The master side is the controller and the slave side is the datapath.
interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic [3:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic       pc_en;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       RegWrite;
    logic       MemtoReg;
    logic       mem_err;
    logic       illegal_op;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output ALUOp, ALUSrcA, ALUSrcB, PCSource, pc_en, IorD, MemRead, MemWrite,
               IRWrite, RegDst, RegWrite, MemtoReg, mem_err, illegal_op
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  ALUOp, ALUSrcA, ALUSrcB, PCSource, pc_en, IorD, MemRead, MemWrite,
               IRWrite, RegDst, RegWrite, MemtoReg, mem_err, illegal_op
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control FSM (fetch/decode/execute/memory/writeback) with memory-wait timeout.
// Define ILLEGAL_TRAP_EN to park in TRAP on an illegal opcode/funct; otherwise it runs as a NOP.
module mc_control_fsm #(
    parameter int WAIT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_control_fsm_if.master bus
);
`ifdef ILLEGAL_TRAP_EN
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, RTYPE_WB, BRANCH, JUMP, ADDI_EX, ADDI_WB, TRAP
    } state_t;
    localparam state_t ILLEGAL_NEXT = TRAP;
`else
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, RTYPE_WB, BRANCH, JUMP, ADDI_EX, ADDI_WB
    } state_t;
    localparam state_t ILLEGAL_NEXT = FETCH;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SUBZ = 4'b0111;

    // Counter value seen in the last allowed wait cycle (2**WAIT_W-1 cycles of waiting in total).
    localparam logic [WAIT_W-1:0] WAIT_LAST = {{(WAIT_W-1){1'b1}}, 1'b0};

    state_t            state_reg;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [5:0]        funct_q_reg;
    logic              mem_err_reg;

    logic              in_wait;
    logic              expire;
    logic              rtype_legal;
    logic [3:0]        rtype_op;

    logic [3:0]        alu_op;
    logic              alu_src_a;
    logic [1:0]        alu_src_b;
    logic [1:0]        pc_source;
    logic              pc_write;
    logic              pc_write_cond;
    logic              iord;
    logic              mem_read;
    logic              mem_write;
    logic              ir_write;
    logic              reg_dst;
    logic              reg_write;
    logic              memto_reg;

    always_comb begin
        rtype_legal = 1'b1;
        rtype_op    = ALU_AND;
        case (funct_q_reg)
            6'b100000: rtype_op = ALU_ADD;
            6'b100010: rtype_op = ALU_SUB;
            6'b100100: rtype_op = ALU_AND;
            6'b100101: rtype_op = ALU_OR;
            default:   rtype_legal = 1'b0;
        endcase
    end

    assign in_wait = (state_reg == FETCH) || (state_reg == MEMRD) || (state_reg == MEMWR);
    assign expire  = in_wait && !bus.mem_ready && (wait_cnt_reg == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            mem_err_reg  <= 1'b0;
            funct_q_reg  <= '0;
        end else begin
            state_reg <= state_next;
            // Counts only uninterrupted waiting; any exit, ready or expiry starts over at zero.
            if (in_wait && !bus.mem_ready && !expire) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end else begin
                wait_cnt_reg <= '0;
            end
            if (expire) begin
                mem_err_reg <= 1'b1;
            end
            if (state_reg == DECODE) begin
                funct_q_reg <= bus.funct;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        alu_op        = ALU_AND;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        memto_reg     = 1'b0;

        case (state_reg)
            IDLE: state_next = FETCH;
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALU_ADD;
                // An expired fetch simply restarts FETCH; the IR and PC stay untouched.
                if (bus.mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = ALU_ADD;
                case (bus.opcode)
                    OP_RTYPE:      state_next = EXEC;
                    OP_LW, OP_SW:  state_next = MEMADR;
                    OP_BEQ:        state_next = BRANCH;
                    OP_J:          state_next = JUMP;
                    OP_ADDI:       state_next = ADDI_EX;
                    default:       state_next = ILLEGAL_NEXT;
                endcase
            end
            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = ALU_ADD;
                state_next = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    state_next = MEMWB;
                end else if (expire) begin
                    state_next = FETCH;
                end
            end
            MEMWB: begin
                reg_write  = 1'b1;
                memto_reg  = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (bus.mem_ready || expire) begin
                    state_next = FETCH;
                end
            end
            EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = rtype_op;
                state_next = rtype_legal ? RTYPE_WB : ILLEGAL_NEXT;
            end
            RTYPE_WB: begin
                alu_op     = rtype_op;
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUBZ;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_next    = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                state_next = FETCH;
            end
            ADDI_EX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = ALU_ADD;
                state_next = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            TRAP: state_next = TRAP;
`endif
            default: state_next = IDLE;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_op_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_op_reg <= 1'b0;
        end else if (state_next == TRAP) begin
            illegal_op_reg <= 1'b1;
        end
    end

    assign bus.illegal_op = illegal_op_reg;
`else
    assign bus.illegal_op = 1'b0;
`endif

    // The state register only clears at the edge, so decoded outputs are forced low while reset is held.
    assign bus.ALUOp    = rst_n ? alu_op    : 4'b0000;
    assign bus.ALUSrcA  = rst_n & alu_src_a;
    assign bus.ALUSrcB  = rst_n ? alu_src_b : 2'b00;
    assign bus.PCSource = rst_n ? pc_source : 2'b00;
    assign bus.pc_en    = rst_n & (pc_write | (pc_write_cond & bus.zero));
    assign bus.IorD     = rst_n & iord;
    assign bus.MemRead  = rst_n & mem_read;
    assign bus.MemWrite = rst_n & mem_write;
    assign bus.IRWrite  = rst_n & ir_write;
    assign bus.RegDst   = rst_n & reg_dst;
    assign bus.RegWrite = rst_n & reg_write;
    assign bus.MemtoReg = rst_n & memto_reg;
    assign bus.mem_err  = mem_err_reg;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: each instruction is expanded into its expected per-cycle
// outputs from the instruction rules and memory-wait counts, then replayed and compared cycle by cycle.
`timescale 1ns/1ps
module tb_mc_control_fsm;
    localparam int WAIT_W = 4;
    localparam int TMO    = (1 << WAIT_W) - 1;

    typedef struct packed {
        logic [3:0] aluop;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic       pc_en;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       regdst;
        logic       regw;
        logic       m2r;
        logic       mem_err;
        logic       illegal;
    } outv_t;

    typedef struct {
        logic       rst_n;
        logic [5:0] op;
        logic [5:0] fn;
        logic       zero;
        logic       rdy;
        outv_t      exp;
        string      note;
    } cyc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_control_fsm_if bus();
    mc_control_fsm #(.WAIT_W(WAIT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    cyc_t  plan[$];
    outv_t pin_m[int];
    outv_t pin_v[int];
    logic  m_err = 1'b0;
    logic  m_ill = 1'b0;
    bit    last_ill;
    string pending_note = "";
    int    checks = 0;
    int    failures = 0;

    function automatic logic [5:0] rnd6();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outv_t ov(input logic [3:0] aluop, input logic srca, input logic [1:0] srcb,
                                 input logic [1:0] pcsrc, input logic pcen, input logic iord,
                                 input logic mr, input logic mw, input logic irw, input logic rdst,
                                 input logic rw, input logic m2r);
        return {aluop, srca, srcb, pcsrc, pcen, iord, mr, mw, irw, rdst, rw, m2r, 2'b00};
    endfunction

    task automatic push(input logic r, input logic rdy, input logic z, input logic [5:0] op,
                        input logic [5:0] fn, input outv_t e);
        cyc_t c;
        e.mem_err = m_err;
        e.illegal = m_ill;
        c.rst_n = r; c.rdy = rdy; c.zero = z; c.op = op; c.fn = fn; c.exp = e;
        c.note = pending_note;
        pending_note = "";
        plan.push_back(c);
    endtask

    task automatic pin(input int idx, input outv_t m, input outv_t v);
        pin_m[idx] = m;
        pin_v[idx] = v;
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            push(1'b0, rb(), rb(), rnd6(), rnd6(), '0);
            m_err = 1'b0;
            m_ill = 1'b0;
        end
        push(1'b1, rb(), rb(), rnd6(), rnd6(), '0);
    endtask

    // Instruction fetch: `waits` not-ready cycles before memory answers; every TMO misses restart it.
    task automatic fetch_phase(input int waits);
        int  c = 0;
        bit  done = 0;
        while (!done) begin
            logic rdy = (waits == 0);
            push(1'b1, rdy, rb(), rnd6(), rnd6(),
                 ov(4'b0010, 1'b0, 2'b01, 2'b00, rdy, 1'b0, 1'b1, 1'b0, rdy, 1'b0, 1'b0, 1'b0));
            if (rdy) begin
                done = 1;
            end else begin
                waits--;
                c++;
                if (c == TMO) begin
                    m_err = 1'b1;
                    c = 0;
                end
            end
        end
    endtask

    task automatic mem_phase(input bit wr, input int waits, output bit ok);
        int c = 0;
        bit done = 0;
        ok = 0;
        while (!done) begin
            logic rdy = (waits == 0);
            push(1'b1, rdy, rb(), rnd6(), rnd6(),
                 ov(4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, !wr, wr, 1'b0, 1'b0, 1'b0, 1'b0));
            if (rdy) begin
                ok = 1;
                done = 1;
            end else begin
                waits--;
                c++;
                if (c == TMO) begin
                    m_err = 1'b1;
                    done = 1;
                end
            end
        end
    endtask

    task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw);
        bit         ok;
        bit         legal;
        logic [3:0] rop;
        last_ill = 0;
        pending_note = $sformatf("op=%02h fn=%02h zero=%0d fetch_wait=%0d mem_wait=%0d",
                                 op, fn, z, fw, mw);
        fetch_phase(fw);
        push(1'b1, rb(), rb(), op, fn,
             ov(4'b0010, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        case (op)
            6'h00: begin
                legal = 1;
                case (fn)
                    6'h20: rop = 4'b0010;
                    6'h22: rop = 4'b0110;
                    6'h24: rop = 4'b0000;
                    6'h25: rop = 4'b0001;
                    default: begin rop = 4'b0000; legal = 0; end
                endcase
                push(1'b1, rb(), rb(), rnd6(), rnd6(),
                     ov(rop, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                if (legal)
                    push(1'b1, rb(), rb(), rnd6(), rnd6(),
                         ov(rop, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
                else
                    last_ill = 1;
            end
            6'h23, 6'h2b: begin
                push(1'b1, rb(), rb(), op, rnd6(),
                     ov(4'b0010, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                mem_phase(op == 6'h2b, mw, ok);
                if (ok && op == 6'h23)
                    push(1'b1, rb(), rb(), rnd6(), rnd6(),
                         ov(4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
            end
            6'h04: push(1'b1, rb(), z, rnd6(), rnd6(),
                        ov(4'b0111, 1'b1, 2'b00, 2'b01, z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            6'h02: push(1'b1, rb(), rb(), rnd6(), rnd6(),
                        ov(4'b0000, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            6'h08: begin
                push(1'b1, rb(), rb(), rnd6(), rnd6(),
                     ov(4'b0010, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                push(1'b1, rb(), rb(), rnd6(), rnd6(),
                     ov(4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
            end
            default: last_ill = 1;
        endcase
`ifdef ILLEGAL_TRAP_EN
        if (last_ill) begin
            m_ill = 1'b1;
            for (int k = 0; k < 4; k++) push(1'b1, rb(), rb(), rnd6(), rnd6(), '0);
            do_reset(2);
        end
`endif
    endtask

    function automatic outv_t sample();
        outv_t a;
        a.aluop = bus.ALUOp;     a.srca = bus.ALUSrcA;   a.srcb = bus.ALUSrcB;
        a.pcsrc = bus.PCSource;  a.pc_en = bus.pc_en;    a.iord = bus.IorD;
        a.mr = bus.MemRead;      a.mw = bus.MemWrite;    a.irw = bus.IRWrite;
        a.regdst = bus.RegDst;   a.regw = bus.RegWrite;  a.m2r = bus.MemtoReg;
        a.mem_err = bus.mem_err; a.illegal = bus.illegal_op;
        return a;
    endfunction

    initial begin
        outv_t m, v, act;
        int    a, b, c, d, e, f, n, len, keep, fw, mw;
        logic [5:0] op, fn;
        bit    cut_ok;

        bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

        // Directed opening: reset, add, lw with 3 waits, beq taken/not taken, fetch timeout, illegal op.
        do_reset(2);
        a = plan.size();
        add_instr(6'h00, 6'h20, 1'b0, 0, 0);
        b = plan.size();
        add_instr(6'h23, 6'h00, 1'b0, 0, 3);
        c = plan.size();
        add_instr(6'h04, 6'h00, 1'b1, 0, 0);
        d = plan.size();
        add_instr(6'h04, 6'h00, 1'b0, 0, 0);
        e = plan.size();
        add_instr(6'h02, 6'h00, 1'b0, 20, 0);
        f = plan.size();
        add_instr(6'h3f, 6'h00, 1'b0, 0, 0);
        add_instr(6'h02, 6'h00, 1'b0, 0, 0);

        m = '1; v = '0; pin(a - 1, m, v);
        m = '0; v = '0; m.aluop = '1; v.aluop = 4'b0010; m.mr = 1; v.mr = 1; pin(a, m, v);
        m = '0; v = '0; m.aluop = '1; v.aluop = 4'b0010; m.srca = 1; v.srca = 1; pin(a + 2, m, v);
        m = '0; v = '0; m.regw = 1; v.regw = 1; m.regdst = 1; v.regdst = 1; pin(a + 3, m, v);
        m = '0; v = '0; m.mr = 1; v.mr = 1; m.irw = 1; v.irw = 1; pin(a + 4, m, v);
        for (int k = 3; k <= 6; k++) begin
            m = '0; v = '0; m.mr = 1; v.mr = 1; m.iord = 1; v.iord = 1; pin(b + k, m, v);
        end
        m = '0; v = '0; m.m2r = 1; v.m2r = 1; m.regw = 1; v.regw = 1; pin(b + 7, m, v);
        m = '0; v = '0; m.pc_en = 1; v.pc_en = 1; m.pcsrc = '1; v.pcsrc = 2'b01;
        m.aluop = '1; v.aluop = 4'b0111; pin(c + 2, m, v);
        m = '0; v = '0; m.pc_en = 1; v.pc_en = 0; pin(d + 2, m, v);
        m = '0; v = '0; m.mem_err = 1; v.mem_err = 0; m.irw = 1; v.irw = 0; pin(e + 14, m, v);
        m = '0; v = '0; m.mem_err = 1; v.mem_err = 1; m.irw = 1; v.irw = 0; m.mr = 1; v.mr = 1;
        pin(e + 15, m, v);
        m = '0; v = '0; m.irw = 1; v.irw = 1; pin(e + 20, m, v);
`ifdef ILLEGAL_TRAP_EN
        m = '0; v = '0; m.illegal = 1; v.illegal = 1; m.mr = 1; v.mr = 0; pin(f + 2, m, v);
`else
        m = '0; v = '0; m.illegal = 1; v.illegal = 0; m.mr = 1; v.mr = 1;
        m.regw = 1; v.regw = 0; m.irw = 1; v.irw = 1; pin(f + 2, m, v);
`endif

        // Random instruction stream with occasional timeouts and mid-instruction resets.
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 9))
                0, 1, 8: op = 6'h00;
                2:       op = 6'h23;
                3:       op = 6'h2b;
                4:       op = 6'h04;
                5:       op = 6'h02;
                6:       op = 6'h08;
                default: op = rnd6();
            endcase
            case ($urandom_range(0, 4))
                0:       fn = 6'h20;
                1:       fn = 6'h22;
                2:       fn = 6'h24;
                3:       fn = 6'h25;
                default: fn = rnd6();
            endcase
            fw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 3));
            n = plan.size();
            add_instr(op, fn, rb(), fw, mw);
            cut_ok = (fw < TMO) && (mw < TMO) && !last_ill;
            len = plan.size() - n;
            if (cut_ok && len >= 2 && $urandom_range(0, 11) == 0) begin
                keep = $urandom_range(1, len - 1);
                while (plan.size() > n + keep) void'(plan.pop_back());
                do_reset($urandom_range(1, 2));
            end
        end

        foreach (plan[i]) begin
            @(posedge clk);
            #1;
            rst_n = plan[i].rst_n;
            bus.opcode = plan[i].op;
            bus.funct = plan[i].fn;
            bus.zero = plan[i].zero;
            bus.mem_ready = plan[i].rdy;
            if (plan[i].note != "") $display("txn cyc=%0d %s", i, plan[i].note);
            #4;
            act = sample();
            checks++;
            if (act !== plan[i].exp) begin
                failures++;
                $display("FAIL outputs cyc=%0d act=%05h exp=%05h", i, act, plan[i].exp);
            end
            if (pin_m.exists(i)) begin
                checks++;
                if ((act & pin_m[i]) !== pin_v[i]) begin
                    failures++;
                    $display("FAIL pinned cyc=%0d act=%05h exp=%05h mask=%05h",
                             i, act & pin_m[i], pin_v[i], pin_m[i]);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
